word_packer: RTL
================

# word_packer

Parametrised beat-to-word packer with valid/ready flow control on both sides. It assembles `BLOCK_SIZE` consecutive `IN_WIDTH`-bit beats into one word, in little- or big-endian lane order. It also supports frame termination: `in_last` emits a zero-padded partial word. It sits between the byte-stream receiver and the sample/command consumers, and replaces fixed 8-bit, fire-and-forget packing wherever backpressure or odd-length frames occur.

## Interface
- `IN_WIDTH`, 8, width of one input beat (≥1).
- `BLOCK_SIZE`, 2, beats per output word (≥1).
- `BIG_ENDIAN`, 0, lane order: 0 = first beat in the lowest lane, 1 = first beat in the highest lane.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data`/`in_last` valid this cycle.
- `in_ready`  out  1  packer accepts a beat this cycle.
- `in_data`  in  `IN_WIDTH`  input beat.
- `in_last`  in  1  beat is the final beat of a frame; forces word emission.
- `out_valid`  out  1  `out_data`/`out_count`/`out_last` hold a word.
- `out_ready`  in  1  consumer takes the word this cycle.
- `out_data`  out  `IN_WIDTH*BLOCK_SIZE`  packed word.
- `out_count`  out  `$clog2(BLOCK_SIZE+1)`  number of filled lanes, 1..`BLOCK_SIZE`.
- `out_last`  out  1  word closes a frame.

## Operation
- A beat is accepted on a cycle where `in_valid && in_ready` (the handshake).
- `in_ready = !out_valid || out_ready`. It is combinational and may depend on `out_ready`; it never depends on `in_valid`.
- Internal state:
  - Lane index `idx` counts 0..`BLOCK_SIZE-1` (width `max(1,$clog2(BLOCK_SIZE))`).
  - Accumulator `acc` has width `IN_WIDTH*BLOCK_SIZE`.
- Lane placement for beat number k within the word:
  - `BIG_ENDIAN=0`: bits `[IN_WIDTH*(k+1)-1 : IN_WIDTH*k]`.
  - `BIG_ENDIAN=1`: lane `BLOCK_SIZE-1-k`.
- Accepted beat, not completing:
  - Completing means `idx == BLOCK_SIZE-1` or `in_last == 1`.
  - The beat is written into its lane of `acc`, and `idx` increments.
- Accepted completing beat:
  - `out_data` receives `acc` with the new beat merged in; all unfilled lanes are 0.
  - `out_count` = `idx+1`, `out_last` = `in_last`, `out_valid` = 1.
  - `acc` is cleared to 0 and `idx` returns to 0.
- Output handshake: when `out_valid && out_ready` with no new completing beat, `out_valid` drops to 0. `out_data`/`out_count`/`out_last` hold their values until overwritten.
- Simultaneous drain and complete (`out_ready=1` and a completing beat accepted in the same cycle): the new word loads and `out_valid` stays 1, giving full throughput.
- Stall (`out_valid=1`, `out_ready=0`):
  - `out_*` are stable and no beat is accepted, including non-completing beats.
  - `acc` and `idx` are frozen.
- `BLOCK_SIZE=1`: every accepted beat completes, with `out_count` = 1.
- `in_last` on the first beat of a word: emits a 1-lane word with `out_count` = 1 and `out_last` = 1.
- Reset, including mid-word or mid-stall:
  - `out_valid`=0, `out_data`=0, `out_count`=0, `out_last`=0, `idx`=0, `acc`=0.
  - The partial word is discarded and the pending output word is dropped.
  - `in_ready` reads 1 from the cycle after reset is sampled high.
- No beat is ever lost or duplicated while `reset` is low.

## Timing
- Latency: completing beat accepted at edge N → `out_valid`=1 and the word visible after edge N.
- Steady state with `out_ready` held 1: one word every `BLOCK_SIZE` accepted beats, with no bubbles.
- `in_ready` responds combinationally to `out_ready` in the same cycle. There is no other combinational input→output path.
- All state updates are gated by the handshakes only; `in_data`/`in_last` are ignored when the handshake is absent.

## Test plan
- **Little-endian packing** (`IN_WIDTH`=8, `BLOCK_SIZE`=2, LE), `out_ready`=1:
  - Stimulus: beats 0x34, 0x12, 0x78, 0x56 on consecutive cycles.
  - Required: `out_data` = 0x1234 then 0x5678, each with `out_count`=2, `out_last`=0.
  - Required: `out_valid` high the cycle after the 2nd and the 4th beat.
- **Big-endian, wide word** (`BIG_ENDIAN`=1, `BLOCK_SIZE`=4):
  - Stimulus: beats 0xAA, 0xBB, 0xCC, 0xDD.
  - Required: `out_data` = 0xAABBCCDD.
- **Frame end, partial word** (`BLOCK_SIZE`=4, LE):
  - Stimulus: beats 0x01, 0x02, 0x03 with `in_last` on 0x03.
  - Required: `out_data` = 0x00030201, `out_count`=3, `out_last`=1.
  - Next frame: beat 0x09 starts at lane 0.
- **Backpressure** (`BLOCK_SIZE`=2):
  - Stimulus: hold `out_ready`=0 after the first word; drive `in_valid`=1 continuously.
  - Required: `in_ready`=0 and `out_data` stable for 5 cycles.
  - Required on release: word 1 drains, then the following words arrive in order, with none lost or duplicated.
- **Reset mid-operation**:
  - Stimulus: assert `reset` after 1 beat of a 2-beat word while a stalled word is pending.
  - Required: all outputs 0 and `out_valid`=0 the next cycle.
  - Required: the next beats 0xEF, 0xBE yield 0xBEEF.
- **`BLOCK_SIZE`=1, `IN_WIDTH`=12**:
  - Stimulus: beats 0xABC, 0x123 back to back, with `out_ready` toggling 1,0,1.
  - Required: the outputs are 0xABC then 0x123 with correct stall behaviour and `out_count`=1.

Source files
------------

// File: rtl/word_packer.sv
// Beat-to-word packer: gathers BLOCK_SIZE beats of IN_WIDTH bits into one word,
// with valid/ready on both sides and in_last flushing a zero-padded partial word.
module word_packer #(
   parameter int unsigned IN_WIDTH   = 8,
   parameter int unsigned BLOCK_SIZE = 2,
   parameter int unsigned BIG_ENDIAN = 0
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [IN_WIDTH-1:0]                    in_data,
   input  logic                                   in_last,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [IN_WIDTH*BLOCK_SIZE-1:0]         out_data,
   output logic [$clog2(BLOCK_SIZE+1)-1:0]        out_count,
   output logic                                   out_last
);

   localparam int unsigned OUT_WIDTH = IN_WIDTH * BLOCK_SIZE;
   localparam int unsigned CNT_WIDTH = $clog2(BLOCK_SIZE + 1);
   localparam int unsigned IDX_WIDTH = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

   logic [IDX_WIDTH-1:0] idx;
   logic [IDX_WIDTH-1:0] lane;
   logic [OUT_WIDTH-1:0] acc;
   logic [OUT_WIDTH-1:0] merged;
   logic                 accept;
   logic                 complete;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign complete = (idx == IDX_WIDTH'(BLOCK_SIZE - 1)) || in_last;

   // Unfilled lanes of acc are always zero, so merging is a single lane write.
   always_comb begin
      lane   = (BIG_ENDIAN != 0) ? (IDX_WIDTH'(BLOCK_SIZE - 1) - idx) : idx;
      merged = acc;
      for (int k = 0; k < int'(BLOCK_SIZE); k++) begin
         if (lane == IDX_WIDTH'(k)) begin
            merged[k*IN_WIDTH +: IN_WIDTH] = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_last  <= 1'b0;
      end else begin
         if (accept) begin
            if (complete) begin
               out_data  <= merged;
               out_count <= CNT_WIDTH'(idx) + CNT_WIDTH'(1);
               out_last  <= in_last;
               acc       <= '0;
               idx       <= '0;
            end else begin
               acc <= merged;
               idx <= idx + IDX_WIDTH'(1);
            end
         end
         // A new word loading in the drain cycle keeps out_valid high.
         if (accept && complete) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
